// File: rtl/led_pkg.sv
// led_pkg: shared constants and FSM state type for the LED PWM driver.
package led_pkg;
    localparam int LED_R_BIT = 2;
    localparam int LED_G_BIT = 1;
    localparam int LED_B_BIT = 0;
    localparam int PWM_BITS_DEFAULT = 8;
    typedef enum logic {IDLE, RUN} led_state_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one LED channel with its duty register, load/fade logic and registered compare.
// LED_PWM_FADE_EN selects stepped fading toward the target instead of a direct load.
module pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] i_cnt,
    input  logic                i_load,
    input  logic                i_clr,
    input  logic                i_run,
    input  logic                i_on,
    input  logic [PWM_BITS-1:0] i_brightness,
    output logic                o_led,
    output logic                o_busy
);
    logic [PWM_BITS-1:0] r_duty;
    logic                r_led;
    logic [PWM_BITS-1:0] w_tgt;
    logic [PWM_BITS-1:0] w_next;

    assign w_tgt = i_on ? i_brightness : '0;

`ifdef LED_PWM_FADE_EN
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);
    // Compare the remaining distance, not the stepped value, so the step can never wrap.
    assign w_next = (r_duty < w_tgt) ? ((w_tgt - r_duty > STEP) ? r_duty + STEP : w_tgt) :
                    (r_duty > w_tgt) ? ((r_duty - w_tgt > STEP) ? r_duty - STEP : w_tgt) : r_duty;
`else
    assign w_next = w_tgt;
`endif

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_duty <= '0;
            r_led  <= 1'b0;
        end else begin
            if (i_load) r_duty <= w_next;
            r_led <= i_run && (i_cnt < r_duty);
        end
    end

    assign o_led  = r_led;
    assign o_busy = i_run && (r_duty != w_tgt);
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: RGB PWM driver with period-aligned duty updates.
// Define LED_PWM_FADE_EN to ramp each channel by FADE_STEP per period.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [2:0]          colour,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                period_start,
    output logic                busy
);
    led_state_t          r_state;
    led_state_t          w_next_state;
    logic [PWM_BITS-1:0] r_cnt;
    logic                r_ps;
    logic                w_run;
    logic                w_clr;
    logic                w_load;
    logic [2:0]          w_led;
    logic [2:0]          w_busy;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = enable ? RUN : IDLE;
    end

    // Boundary is the edge where the counter enters 0, including the IDLE->RUN entry.
    always_comb begin
        w_run  = (r_state == RUN);
        w_clr  = !enable;
        w_load = enable && (r_state == IDLE || r_cnt == '1);
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_cnt <= '0;
            r_ps  <= 1'b0;
        end else begin
            r_cnt <= w_run ? r_cnt + 1'b1 : '0;
            r_ps  <= w_run && (r_cnt == '0);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        pwm_channel #(.PWM_BITS(PWM_BITS), .FADE_STEP(FADE_STEP)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_cnt       (r_cnt),
            .i_load      (w_load),
            .i_clr       (w_clr),
            .i_run       (w_run),
            .i_on        (colour[i]),
            .i_brightness(brightness),
            .o_led       (w_led[i]),
            .o_busy      (w_busy[i])
        );
    end

    assign led_r        = w_led[LED_R_BIT];
    assign led_g        = w_led[LED_G_BIT];
    assign led_b        = w_led[LED_B_BIT];
    assign period_start = r_ps;
    assign busy         = |w_busy;
endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Downstream stage of the dynamic LED colour cycler: consumes its 3-bit `colour` code and drives the three physical RGB LED pins with pulse-width modulation at a programmable brightness. Duty changes are applied only at PWM period boundaries, so no partial or glitched periods occur. An optional soft fade ramps each channel toward its new level instead of switching abruptly.

## Interface
Parameters:
- `PWM_BITS`, default 8: counter and duty width; PWM period is 2^PWM_BITS cycles.
- `FADE_STEP`, default 1: duty increment/decrement per period when fading.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: run PWM; low forces outputs off.
- `colour`, in, 3: colour code from the cycler. Bit 2 is R, bit 1 is G, bit 0 is B.
- `brightness`, in, `PWM_BITS`: on-level duty for any lit channel.
- `led_r`, `led_g`, `led_b`, out, 1 each: registered PWM outputs.
- `period_start`, out, 1: one-cycle pulse at counter value 0.
- `busy`, out, 1: high while any channel duty differs from its target.

## Operation
- FSM states:
  - IDLE: counter held at 0, all current duties are 0, outputs are 0.
  - RUN: counter free-runs from 0 to 2^PWM_BITS−1 and wraps.
- FSM transitions:
  - IDLE→RUN when `enable`=1.
  - RUN→IDLE when `enable`=0, from any counter value (mid-period abort). Current duties clear to 0.
- Target per channel: `colour` bit ? `brightness` : 0.
  - Colour 0 gives all channels 0.
  - Colour 7 gives all three channels at `brightness`.
- Duty update point: `duty_cur` changes only on the edge where the counter enters 0, including the IDLE→RUN entry. `colour` and `brightness` are sampled at that edge; changes between boundaries have no effect until the next one.
- Output compare: `led_x` is 1 iff counter < `duty_cur`.
  - Duty 0 gives constantly off.
  - Duty 2^PWM_BITS−1 gives on for all but one cycle of the period; no 100% duty.
- `busy` = RUN and any `duty_cur` ≠ its current target (combinational from registers).
- Arithmetic: fade steps are unsigned and saturate at the target, with no overshoot and no wrap below 0 or above 2^PWM_BITS−1.

## Timing
- Reset values: counter 0, all `duty_cur` 0, `led_r`/`led_g`/`led_b` 0, `period_start` 0, `busy` 0, state IDLE.
- Output latency: `led_x` and `period_start` are registered and lag the counter/duty registers by one cycle. After IDLE→RUN, the first `period_start` is seen 2 cycles after `enable` rises.
- Colour-to-light latency without fade: at most 2^PWM_BITS+1 cycles from a `colour` change to the first affected output cycle.
- Simultaneous events:
  - `rst` overrides `enable`.
  - `enable` falling on a boundary edge goes to IDLE; no duty load occurs.
- Reset mid-period: all outputs are 0 the cycle after `rst` is sampled high.

## Configuration
- `LED_PWM_FADE_EN` defined: at each boundary, each `duty_cur` moves toward its target by `FADE_STEP`, clamped at the target. `busy` may remain high for multiple periods.
- `LED_PWM_FADE_EN` not defined: at each boundary, `duty_cur` loads the target directly. `busy` is high from a target change until the next boundary, and never longer than one period.

## Structure
- Shared package `led_pkg`:
  - colour bit index constants `LED_R_BIT`=2, `LED_G_BIT`=1, `LED_B_BIT`=0;
  - FSM state typedef {IDLE, RUN};
  - default `PWM_BITS`.
- Sub-module `pwm_channel`, instantiated three times. It holds one `duty_cur` register, the fade/load logic, and the compare/output register. It receives the shared counter, the boundary strobe and the clear signal from the top-level FSM.

## Test plan
Benches use `PWM_BITS`=4 (16-cycle period) and `brightness`=8.
- Reset with `enable`=1 held → all outputs and `busy` are 0 during reset. First `period_start` occurs 2 cycles after `rst` falls.
- `colour`=3'b100, fade off → `led_r` is high 8 cycles and low 8 cycles per period; `led_g` and `led_b` stay 0.
- `colour` changes 1→6 mid-period → no change until the next boundary. Then `led_r` and `led_g` run at 8/16 and `led_b` is 0; `busy` drops at that boundary.
- `colour`=7 with `brightness`=15 → each LED is low for exactly 1 cycle per period. `colour`=0 → all outputs stay 0.
- `LED_PWM_FADE_EN` defined, `FADE_STEP`=2, `colour` 0→4 → R duty goes 2, 4, 6, 8 over four successive periods, then holds. `busy` is high for exactly four boundaries.
- `enable` dropped at counter 5 → outputs are 0 next cycle. Re-enable → restart from counter 0 with duties reloaded (fade off) or ramped from 0 (fade on).
